// File: rtl/pc_sequencer.sv
// pc_sequencer: the program-sequencing unit. It owns the program counter,
// a multi-level call/interrupt stack and a prioritised, vectored interrupt
// controller.
//
// Optional feature:
//   TRSQ_IRQ_NEST_EN - when defined, a higher-priority channel preempts a
//                      running ISR. When undefined there is no preemption.
//
// Ports:
//   clk_ip        in   clock; all state updates on the rising edge
//   reset_n_ip    in   asynchronous active-low reset
//   en_ip         in   advance enable (0 = stall)
//   halt_ip       in   hold PC
//   skip_ip       in   PC + 2
//   jump_ip       in   load target_ip
//   call_ip       in   push PC + 1, load target_ip
//   return_ip     in   pop PC
//   reti_ip       in   pop PC and restore the priority level
//   target_ip     in   jump/call destination
//   irq_ip        in   level interrupt requests, channel 0 highest priority
//   ie_we_ip      in   write strobe for the interrupt-enable register
//   ie_wdata_ip   in   [IRQ_N] global enable, [IRQ_N-1:0] channel masks
//   pc_op         out  program counter (registered)
//   ie_op         out  interrupt-enable register readback
//   irq_ack_op    out  one-hot, one-cycle acknowledge of the taken channel
//   in_isr_op     out  an interrupt priority level is active
//   depth_op      out  number of occupied stack entries
//   stack_ovf_op  out  sticky stack overflow
//   stack_unf_op  out  sticky stack underflow
module pc_sequencer #(
    parameter int PC_W        = 13,
    parameter int STACK_DEPTH = 4,
    parameter int IRQ_N       = 4,
    parameter int VEC_BASE    = 4,
    parameter int VEC_STRIDE  = 4
) (
    input  logic                           clk_ip,
    input  logic                           reset_n_ip,
    input  logic                           en_ip,
    input  logic                           halt_ip,
    input  logic                           skip_ip,
    input  logic                           jump_ip,
    input  logic                           call_ip,
    input  logic                           return_ip,
    input  logic                           reti_ip,
    input  logic [PC_W-1:0]                target_ip,
    input  logic [IRQ_N-1:0]               irq_ip,
    input  logic                           ie_we_ip,
    input  logic [IRQ_N:0]                 ie_wdata_ip,
    output logic [PC_W-1:0]                pc_op,
    output logic [IRQ_N:0]                 ie_op,
    output logic [IRQ_N-1:0]               irq_ack_op,
    output logic                           in_isr_op,
    output logic [$clog2(STACK_DEPTH+1)-1:0] depth_op,
    output logic                           stack_ovf_op,
    output logic                           stack_unf_op
);

    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
    localparam int PTR_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int LVL_W   = $clog2(IRQ_N + 1);
    localparam int IDX_W   = (IRQ_N > 1) ? $clog2(IRQ_N) : 1;

    logic [PC_W-1:0]    pc_q, pc_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic [LVL_W-1:0]   lvl_q, lvl_d;
    logic [IRQ_N:0]     ie_q;
    logic [IRQ_N-1:0]   ack_q, ack_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;

    logic [PC_W-1:0]    stk_pc  [STACK_DEPTH];
    logic [LVL_W-1:0]   stk_lvl [STACK_DEPTH];

    logic [IRQ_N-1:0]   pending;
    logic [IDX_W-1:0]   win_idx;
    logic               eligible;
    logic               take;
    logic               full, empty;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic               push;
    logic [PC_W-1:0]    push_pc;
    logic [LVL_W-1:0]   push_lvl;
    logic [PC_W-1:0]    vec_addr;

    assign pending = irq_ip & ie_q[IRQ_N-1:0] & {IRQ_N{ie_q[IRQ_N]}};
    assign full    = (depth_q == DEPTH_W'(STACK_DEPTH));
    assign empty   = (depth_q == '0);
    assign wr_ptr  = PTR_W'(depth_q);
    assign rd_ptr  = PTR_W'(depth_q - DEPTH_W'(1));

    // Scan from the top down so the lowest pending index wins.
    always_comb begin
        win_idx = '0;
        for (int i = IRQ_N - 1; i >= 0; i--) begin
            if (pending[i]) win_idx = IDX_W'(i);
        end
    end

    assign vec_addr = PC_W'(VEC_BASE) + PC_W'(VEC_STRIDE) * PC_W'(win_idx);

`ifdef TRSQ_IRQ_NEST_EN
    assign eligible = (LVL_W'(win_idx) < lvl_q);
`else
    assign eligible = (lvl_q == LVL_W'(IRQ_N));
`endif

    assign take = en_ip && (pending != '0) && !full && eligible;

    always_comb begin
        pc_d     = pc_q;
        depth_d  = depth_q;
        lvl_d    = lvl_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        ack_d    = '0;
        push     = 1'b0;
        push_pc  = pc_q;
        push_lvl = lvl_q;
        if (take) begin
            // A halted core resumes after the halt instead of re-halting.
            push     = 1'b1;
            push_pc  = halt_ip ? pc_q + PC_W'(1) : pc_q;
            push_lvl = lvl_q;
            depth_d  = depth_q + DEPTH_W'(1);
            pc_d     = vec_addr;
            lvl_d    = LVL_W'(win_idx);
            ack_d[win_idx] = 1'b1;
        end else if (en_ip) begin
            if (reti_ip || return_ip) begin
                if (empty) begin
                    pc_d  = pc_q + PC_W'(1);
                    unf_d = 1'b1;
                end else begin
                    pc_d    = stk_pc[rd_ptr];
                    depth_d = depth_q - DEPTH_W'(1);
                    if (reti_ip) lvl_d = stk_lvl[rd_ptr];
                end
            end else if (call_ip) begin
                pc_d = target_ip;
                if (full) begin
                    ovf_d = 1'b1;
                end else begin
                    push     = 1'b1;
                    push_pc  = pc_q + PC_W'(1);
                    push_lvl = lvl_q;
                    depth_d  = depth_q + DEPTH_W'(1);
                end
            end else if (jump_ip) begin
                pc_d = target_ip;
            end else if (halt_ip) begin
                pc_d = pc_q;
            end else if (skip_ip) begin
                pc_d = pc_q + PC_W'(2);
            end else begin
                pc_d = pc_q + PC_W'(1);
            end
        end
    end

    always_ff @(posedge clk_ip or negedge reset_n_ip) begin
        if (!reset_n_ip) begin
            pc_q    <= '0;
            depth_q <= '0;
            lvl_q   <= LVL_W'(IRQ_N);
            ie_q    <= '0;
            ack_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            depth_q <= depth_d;
            lvl_q   <= lvl_d;
            ack_q   <= ack_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            if (ie_we_ip) ie_q <= ie_wdata_ip;
        end
    end

    // Stack storage needs no reset: depth_q alone defines what is valid.
    always_ff @(posedge clk_ip) begin
        if (push) begin
            stk_pc[wr_ptr]  <= push_pc;
            stk_lvl[wr_ptr] <= push_lvl;
        end
    end

    assign pc_op        = pc_q;
    assign ie_op        = ie_q;
    assign irq_ack_op   = ack_q;
    assign in_isr_op    = (lvl_q != LVL_W'(IRQ_N));
    assign depth_op     = depth_q;
    assign stack_ovf_op = ovf_q;
    assign stack_unf_op = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    logic        clk_ip = 1'b0;
    logic        reset_n_ip;
    logic        en_ip, halt_ip, skip_ip, jump_ip, call_ip, return_ip, reti_ip;
    logic [12:0] target_ip;
    logic [3:0]  irq_ip;
    logic        ie_we_ip;
    logic [4:0]  ie_wdata_ip;
    logic [12:0] pc_op;
    logic [4:0]  ie_op;
    logic [3:0]  irq_ack_op;
    logic        in_isr_op;
    logic [2:0]  depth_op;
    logic        stack_ovf_op, stack_unf_op;

    int n_chk  = 0;
    int n_pass = 0;

    pc_sequencer dut (
        .clk_ip       (clk_ip),
        .reset_n_ip   (reset_n_ip),
        .en_ip        (en_ip),
        .halt_ip      (halt_ip),
        .skip_ip      (skip_ip),
        .jump_ip      (jump_ip),
        .call_ip      (call_ip),
        .return_ip    (return_ip),
        .reti_ip      (reti_ip),
        .target_ip    (target_ip),
        .irq_ip       (irq_ip),
        .ie_we_ip     (ie_we_ip),
        .ie_wdata_ip  (ie_wdata_ip),
        .pc_op        (pc_op),
        .ie_op        (ie_op),
        .irq_ack_op   (irq_ack_op),
        .in_isr_op    (in_isr_op),
        .depth_op     (depth_op),
        .stack_ovf_op (stack_ovf_op),
        .stack_unf_op (stack_unf_op)
    );

    always #5 clk_ip = ~clk_ip;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk_ip);
        #1;
    endtask

    task automatic clr_strobes();
        halt_ip = 0; skip_ip = 0; jump_ip = 0; call_ip = 0;
        return_ip = 0; reti_ip = 0; ie_we_ip = 0;
    endtask

    task automatic do_jump(input logic [12:0] t);
        jump_ip = 1; target_ip = t;
        step();
        jump_ip = 0;
    endtask

    task automatic write_ie(input logic [4:0] v);
        ie_we_ip = 1; ie_wdata_ip = v;
        step();
        ie_we_ip = 0;
    endtask

    task automatic do_reti();
        reti_ip = 1;
        step();
        reti_ip = 0;
    endtask

    initial begin
        reset_n_ip = 0; en_ip = 0; clr_strobes();
        target_ip = '0; irq_ip = '0; ie_wdata_ip = '0;
        repeat (2) @(posedge clk_ip);
        #1;
        chk("rst_pc", 32'(pc_op), 0);
        chk("rst_ie", 32'(ie_op), 0);
        chk("rst_ack", 32'(irq_ack_op), 0);
        chk("rst_isr", 32'(in_isr_op), 0);
        chk("rst_depth", 32'(depth_op), 0);
        chk("rst_flags", 32'({stack_ovf_op, stack_unf_op}), 0);
        reset_n_ip = 1; en_ip = 1;

        // sequencing
        for (int i = 1; i <= 3; i++) begin
            step();
            chk("inc", 32'(pc_op), 32'(i));
        end
        skip_ip = 1; step(); skip_ip = 0;
        chk("skip", 32'(pc_op), 5);
        do_jump(13'h100);
        chk("jump", 32'(pc_op), 32'h100);
        do_jump(13'h1FFF);
        chk("jump_top", 32'(pc_op), 32'h1FFF);
        step();
        chk("wrap", 32'(pc_op), 0);

        // call/return nesting
        do_jump(13'h10);
        call_ip = 1; target_ip = 13'h40; step();
        chk("call1_pc", 32'(pc_op), 32'h40);
        target_ip = 13'h80; step(); call_ip = 0;
        chk("call2_pc", 32'(pc_op), 32'h80);
        chk("call2_depth", 32'(depth_op), 2);
        return_ip = 1; step();
        chk("ret1_pc", 32'(pc_op), 32'h41);
        step();
        chk("ret2_pc", 32'(pc_op), 32'h11);
        chk("ret2_depth", 32'(depth_op), 0);
        chk("unf_before", 32'(stack_unf_op), 0);
        step(); return_ip = 0;
        chk("unf_pc", 32'(pc_op), 32'h12);
        chk("unf_flag", 32'(stack_unf_op), 1);

        // stall
        en_ip = 0; call_ip = 1; target_ip = 13'h99;
        step(); step();
        chk("stall_pc", 32'(pc_op), 32'h12);
        chk("stall_depth", 32'(depth_op), 0);
        en_ip = 1; call_ip = 0;

        // overflow
        do_jump(13'h200);
        call_ip = 1;
        for (int i = 0; i < 5; i++) begin
            target_ip = 13'h300 + 13'(i * 16);
            step();
            if (i == 3) chk("ovf_before", 32'(stack_ovf_op), 0);
        end
        call_ip = 0;
        chk("ovf_pc", 32'(pc_op), 32'h340);
        chk("ovf_depth", 32'(depth_op), 4);
        chk("ovf_flag", 32'(stack_ovf_op), 1);
        write_ie(5'b1_1111);
        irq_ip = 4'b0001;
        step();
        chk("full_irq_pc", 32'(pc_op), 32'h342);
        chk("full_irq_ack", 32'(irq_ack_op), 0);
        irq_ip = 0;

        // asynchronous reset mid-operation
        #2 reset_n_ip = 0;
        #1;
        chk("arst_pc", 32'(pc_op), 0);
        chk("arst_depth", 32'(depth_op), 0);
        chk("arst_flags", 32'({stack_ovf_op, stack_unf_op}), 0);
        chk("arst_ie", 32'(ie_op), 0);
        reset_n_ip = 1;

        // vectored interrupt
        write_ie(5'b1_0100);
        chk("ie_rb", 32'(ie_op), 32'h14);
        do_jump(13'h20);
        irq_ip = 4'b0100; step();
        chk("vec_pc", 32'(pc_op), 12);
        chk("vec_ack", 32'(irq_ack_op), 32'b0100);
        chk("vec_isr", 32'(in_isr_op), 1);
        irq_ip = 0; step();
        chk("ack_1cyc", 32'(irq_ack_op), 0);
        do_reti();
        chk("reti_pc", 32'(pc_op), 32'h20);
        chk("reti_isr", 32'(in_isr_op), 0);

        // halt wake and priority
        write_ie(5'b1_1111);
        do_jump(13'h30);
        halt_ip = 1; irq_ip = 4'b0011; step();
        halt_ip = 0; irq_ip = 0;
        chk("halt_vec", 32'(pc_op), 4);
        chk("halt_ack", 32'(irq_ack_op), 32'b0001);
        do_reti();
        chk("halt_wake", 32'(pc_op), 32'h31);

        // take decision uses the old ie value
        write_ie(5'b1_0001);
        do_jump(13'h50);
        ie_we_ip = 1; ie_wdata_ip = 5'b0_0001; irq_ip = 4'b0001; step(); ie_we_ip = 0;
        chk("oldie_pc", 32'(pc_op), 4);
        chk("oldie_ack", 32'(irq_ack_op), 1);
        chk("oldie_ie", 32'(ie_op), 32'h01);
        do_reti();
        chk("gdis_reti", 32'(pc_op), 32'h50);
        step();
        chk("gdis_pc", 32'(pc_op), 32'h51);
        chk("gdis_ack", 32'(irq_ack_op), 0);
        write_ie(5'b1_0001);
        chk("reen_pc", 32'(pc_op), 32'h52);
        step();
        chk("reen_take", 32'(pc_op), 4);
        step();
        chk("same_lvl", 32'(pc_op), 5);
        do_reti();
        chk("lvl_reti", 32'(pc_op), 32'h52);
        step();
        chk("retake_pc", 32'(pc_op), 4);
        chk("retake_ack", 32'(irq_ack_op), 1);
        irq_ip = 0;
        do_reti();
        chk("retake_ret", 32'(pc_op), 32'h52);
        chk("retake_depth", 32'(depth_op), 0);

        // nesting
        write_ie(5'b1_1111);
        do_jump(13'h60);
        irq_ip = 4'b0100; step();
        chk("n_ch2_pc", 32'(pc_op), 12);
        irq_ip = 4'b0010; step();
`ifdef TRSQ_IRQ_NEST_EN
        chk("n_pre_pc", 32'(pc_op), 8);
        chk("n_pre_depth", 32'(depth_op), 2);
        chk("n_pre_ack", 32'(irq_ack_op), 32'b0010);
        irq_ip = 4'b1000; step();
        chk("n_ch3_pc", 32'(pc_op), 9);
        chk("n_ch3_ack", 32'(irq_ack_op), 0);
        irq_ip = 0;
        do_reti();
        chk("n_reti1_pc", 32'(pc_op), 12);
        chk("n_reti1_isr", 32'(in_isr_op), 1);
        do_reti();
        chk("n_reti2_pc", 32'(pc_op), 32'h60);
        chk("n_reti2_isr", 32'(in_isr_op), 0);
`else
        chk("n_wait_pc", 32'(pc_op), 13);
        chk("n_wait_depth", 32'(depth_op), 1);
        chk("n_wait_ack", 32'(irq_ack_op), 0);
        do_reti();
        chk("n_reti_pc", 32'(pc_op), 32'h60);
        step();
        chk("n_late_pc", 32'(pc_op), 8);
        chk("n_late_ack", 32'(irq_ack_op), 32'b0010);
        irq_ip = 0;
        do_reti();
        chk("n_late_ret", 32'(pc_op), 32'h60);
        chk("n_late_depth", 32'(depth_op), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-sequencing unit for the next TRSQ core generation.
- Owns the program counter, a multi-level hardware call/interrupt stack and a prioritised, vectored interrupt controller.
- Replaces the single-level stack and fixed single interrupt vector of the current core.
- Sits between the instruction decoder (control strobes in) and the program ROM address bus (`pc_op` out).

## Interface
Parameters:
- `PC_W`, 13, program counter / ROM address width
- `STACK_DEPTH`, 4, number of stack entries (≥1)
- `IRQ_N`, 4, interrupt channels; channel 0 has the highest priority
- `VEC_BASE`, 4, address of the channel-0 vector
- `VEC_STRIDE`, 4, address distance between consecutive vectors

Ports:
- `clk_ip` in 1: single clock; all state updates on its rising edge
- `reset_n_ip` in 1: reset, asynchronous, active-low
- `en_ip` in 1: advance enable; 0 = stall, PC and stack hold
- `halt_ip` in 1: hold PC
- `skip_ip` in 1: PC+2
- `jump_ip` in 1: load `target_ip`
- `call_ip` in 1: push PC+1, load `target_ip`
- `return_ip` in 1: pop PC
- `reti_ip` in 1: pop PC, restore priority level
- `target_ip` in PC_W: jump/call destination
- `irq_ip` in IRQ_N: level interrupt requests
- `ie_we_ip` in 1: write the interrupt-enable register
- `ie_wdata_ip` in IRQ_N+1: [IRQ_N] = global enable, [IRQ_N-1:0] = channel masks
- `pc_op` out PC_W: program counter (registered)
- `ie_op` out IRQ_N+1: interrupt-enable register readback
- `irq_ack_op` out IRQ_N: one-hot, one-cycle acknowledge of the taken channel
- `in_isr_op` out 1: an interrupt priority level is active
- `depth_op` out $clog2(STACK_DEPTH+1): number of occupied stack entries
- `stack_ovf_op` out 1: sticky overflow flag
- `stack_unf_op` out 1: sticky underflow flag

## Operation
- **Stack entry:** {pc[PC_W], prev_lvl, irq_frame}.
- **`cur_lvl`:** internal register, 0..IRQ_N; IRQ_N = no ISR active. `in_isr_op` = (`cur_lvl` != IRQ_N).
- **Pending:** `pending` = `irq_ip` & `ie`[IRQ_N-1:0] & {IRQ_N{`ie`[IRQ_N]}`}`. The winner is the lowest pending index.
- **Take condition:** `en_ip` = 1 & `pending` != 0 & stack not full & eligible.
  - Eligible means `cur_lvl` == IRQ_N, or as set by the Configuration section.
- **On take:**
  - Push {ret, `cur_lvl`, 1}, where ret = `pc_op`. If `halt_ip` = 1, ret = `pc_op`+1 (wake from halt).
  - `pc_op` ← VEC_BASE + idx·VEC_STRIDE.
  - `cur_lvl` ← idx.
  - `irq_ack_op`[idx] ← 1 for one cycle.
  - All other control strobes in that cycle are ignored. The interrupted instruction re-executes after `reti`.
- **Otherwise, when `en_ip` = 1, priority is:** `reti` > `return` > `call` > `jump` > `halt` > `skip` > increment.
  - `reti`: pop; `pc_op` ← entry.pc; `cur_lvl` ← entry.prev_lvl.
  - `return`: pop; `pc_op` ← entry.pc; `cur_lvl` unchanged.
  - `call`: push {`pc_op`+1, `cur_lvl`, 0}; `pc_op` ← `target_ip`.
  - `jump`: `pc_op` ← `target_ip`.
  - `halt`: hold. `skip`: `pc_op`+2. Increment: `pc_op`+1.
- **Stack full:**
  - `call`: push is dropped, the jump still happens, `stack_ovf_op` ← 1.
  - Interrupt: not taken, stays pending.
- **Stack empty:** `return`/`reti` → `pc_op`+1, `cur_lvl` unchanged, `stack_unf_op` ← 1.
- **Sticky flags:** cleared only by reset.
- **PC arithmetic:** modulo 2^PC_W; wraps silently.
- **`ie` register:** written whenever `ie_we_ip` = 1, independent of `en_ip`. The take decision in the same cycle uses the old value.
- **Level-sensitive requests:** a request still asserted after `reti` is taken again.

## Timing
- **Reset values:** `pc_op` = 0, `ie_op` = 0, `irq_ack_op` = 0, `in_isr_op` = 0, `depth_op` = 0, both sticky flags = 0. Internally `cur_lvl` = IRQ_N.
- **Latency:** inputs are sampled at edge N; `pc_op`, `depth_op`, `irq_ack_op` and `in_isr_op` reflect the result after edge N (1-cycle latency).
- **Acknowledge:** `irq_ack_op` is high during the same cycle `pc_op` shows the vector. The peripheral must drop its request before the ISR ends.
- **Stall:** `en_ip` = 0 freezes PC, stack, `cur_lvl` and flags. No interrupt is taken and `irq_ack_op` = 0.
- **Reset mid-operation:** asynchronous assertion clears everything immediately. The stack contents become don't-care; `depth_op` = 0.
- **Combinational paths:** none from inputs to outputs.

## Configuration
- **`TRSQ_IRQ_NEST_EN` defined:** an interrupt is eligible when idx < `cur_lvl`, so a higher-priority channel preempts a running ISR. Nested frames restore levels in LIFO order.
- **Undefined:** eligible only when `cur_lvl` == IRQ_N; there is no preemption. A pending request waits for `reti`.

## Test plan
- **Reset/sequencing:** release reset, 3 cycles increment → `pc_op` 0,1,2,3. Then `skip_ip` → 5. Then `jump_ip` with `target_ip`=0x100 → 0x100. Then `pc_op` at 0x1FFF (PC_W=13) + increment → 0x0000.
- **Call/return nesting:** at 0x10, call 0x40; at 0x40, call 0x80. `depth_op` = 2. Two returns → 0x41, then 0x11, `depth_op` = 0. A further return → `pc_op`+1, `stack_unf_op` = 1.
- **Overflow:** 5 calls with STACK_DEPTH=4 → fifth lands on target, `depth_op` = 4, `stack_ovf_op` = 1. An interrupt raised now keeps `pc_op` advancing with no ack.
- **Vectored interrupt:** `ie` = 0b1_0100, `irq_ip`[2] = 1 at `pc_op`=0x20 → `pc_op` = 12, `irq_ack_op` = 0b0100, `in_isr_op` = 1. Drop the request; `reti` → 0x20, `in_isr_op` = 0.
- **Halt wake / priority:** halt at 0x30 with `irq_ip` = 0b0011, `ie` = 0b1_1111 → vector 4 (channel 0), pushed return 0x31. The global-enable write (`ie` 0b1_0001 → 0b0_0001) in the same cycle as a request still takes it, because the decision uses the old `ie`.
- **Nesting, with `TRSQ_IRQ_NEST_EN`:** in the channel-2 ISR, raise channel 1 → preempts to vector 8, `depth_op` = 2. Raise channel 3 → no take. Without the macro, channel 1 waits until after `reti`.
